disp_counter_n: RTL and testbench
=================================

# disp_counter_n

Parametrised N-digit up/down counter with built-in multiplexed 7-segment driver. Generalises the fixed 4-digit hex display counter: digit count, tick rate and scan rate are parameters; adds BCD mode, count direction, parallel load and a wrap pulse. It sits between board I/O (buttons, display anodes and cathodes) and any logic that needs a visible count.

## Interface
- `DIGITS`, 4: number of display digits (1–8); the counter is `4*DIGITS` bits wide.
- `TICK_DIV`, 262144: clk cycles per count tick (≥2).
- `SCAN_DIV`, 2048: clk cycles each digit stays lit (≥1).
- `BCD`, 0: 0 selects a hex counter, 1 selects a decimal counter with per-digit 0–9.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `ce`  in  1  count enable; 0 holds the count.
- `up`  in  1  1 counts up, 0 counts down.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  4*DIGITS  value loaded when `load`=1.
- `value`  out  4*DIGITS  current count; digit k is bits [4k+3:4k].
- `wrap`  out  1  one-cycle pulse on counter wrap-around.
- `ano`  out  DIGITS  digit anodes, active-low, one-hot-zero.
- `cat`  out  8  segments `{P,G,F,E,D,C,B,A}`, active-low; `P` is always 1.

## Operation
- Reset (`reset_n`=0 at a clk edge): prescaler 0, `value` 0, `wrap` 0, scan counter 0, digit index 0, `ano` all ones, `cat` 8'hFF. Reset overrides every other input. Reset mid-scan or mid-tick restarts both dividers from 0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. Internal `tick`=1 for exactly one cycle when the prescaler equals TICK_DIV-1. It free-runs regardless of `ce`. `load` does not reset it.
- Counter priority: `load` > (`tick` && `ce`) > hold.
  - `load`: `value` ← `load_val`; `wrap` stays 0.
  - Hex count: ±1 modulo 2^(4*DIGITS). Up from all-F gives 0. Down from 0 gives all-F.
  - BCD count: digit-wise decimal with ripple carry or borrow. Up from all-9 gives 0. Down from 0 gives all-9. An up-count from a loaded digit >9 sets that digit to 0 and carries. A down-count from a digit >9 gives digit−1 with no borrow.
- `wrap`: registered alongside `value`. It is 1 for the one cycle following a tick update that wrapped (up from max, or down from 0). Otherwise 0.
- Scan: the scan counter counts 0..SCAN_DIV-1. On its terminal count, the digit index advances 0→1→…→DIGITS-1→0.
- Output registers, updated every cycle:
  - `ano` ← all ones with bit[index] = 0.
  - `cat` ← segment code of digit[index] of the current `value`.
- Segment codes (hex, active-low, P=1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.

## Timing
- `value` and `wrap` update on the clk edge that samples `load`, or that samples `tick`&&`ce`. There is one cycle of latency from the input to the output.
- `ano` and `cat` lag the digit index and `value` by one cycle. They are always mutually consistent, with no glitch between anode and segment.
- The first lit digit is digit 0, on the cycle after `reset_n` rises.
- A count update reaches `cat` on the following edge if that digit is currently selected.
- `ce` and `up` are sampled only on tick cycles. `load` is sampled every cycle.

## Configuration
- `DISP_BLANK_EN` defined: leading-zero blanking. A digit k>0 whose value, and the value of all digits above it, is 0 drives `cat` = 8'hFF while selected. Digit 0 is never blanked. `ano` scanning is unchanged.
- `DISP_BLANK_EN` undefined: every digit shows its code, including leading zeros.

## Test plan
Parameters: DIGITS=4, TICK_DIV=4, SCAN_DIV=2 unless stated.
- Reset: hold `reset_n`=0 for 3 cycles, then release → during reset `value`=0, `ano`=4'hF, `cat`=8'hFF; one cycle after release `ano`=4'b1110, `cat`=8'hC0.
- Hex count, `ce`=1, `up`=1, `load_val`=16'hFFFE loaded → after 2 ticks `value`=16'h0000 and `wrap` pulses for exactly 1 cycle; `ce`=0 for 10 ticks → `value` unchanged.
- BCD=1, load 16'h0000, `up`=0 → after 1 tick `value`=16'h9999 with a `wrap` pulse; after a further tick `value`=16'h9998.
- Priority: `load`=1 with `load_val`=16'h1234 on a tick cycle with `ce`=1 → `value`=16'h1234, not 16'h1235, and `wrap`=0.
- Scan: `value`=16'hA5C3 held → `ano` sequence 1110, 1101, 1011, 0111, each held for 2 cycles, with `cat` 8'hB0, C6, 92, 88 respectively.
- With `DISP_BLANK_EN`, `value`=16'h0070 → `cat` sequence C0, F8, FF, FF; without the macro → C0, F8, C0, C0.

Source files
------------

// File: rtl/disp_counter_n.sv
`default_nettype none
// ============================================================================
// Module      : disp_counter_n
// Description : N-digit hex/BCD up/down counter with parallel load, wrap pulse
//               and a built-in multiplexed 7-segment display driver.
//               Optional build macro DISP_BLANK_EN enables leading-zero
//               blanking on the segment outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_counter_n #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 262144,
    parameter int SCAN_DIV = 2048,
    parameter int BCD      = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] value,
    output logic                wrap,
    output logic [DIGITS-1:0]   ano,
    output logic [7:0]          cat
);

    localparam int C_W  = 4 * DIGITS;
    localparam int C_PW = $clog2(TICK_DIV);
    localparam int C_SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int C_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [C_PW-1:0] C_PRE_LAST  = C_PW'(TICK_DIV - 1);
    localparam logic [C_SW-1:0] C_SCAN_LAST = C_SW'(SCAN_DIV - 1);
    localparam logic [C_IW-1:0] C_IDX_LAST  = C_IW'(DIGITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [C_PW-1:0]   prescale_q, prescale_d;
    logic [C_W-1:0]    value_q,    value_d;
    logic              wrap_q,     wrap_d;
    logic [C_SW-1:0]   scan_q,     scan_d;
    logic [C_IW-1:0]   idx_q,      idx_d;
    logic [DIGITS-1:0] ano_q,      ano_d;
    logic [7:0]        cat_q,      cat_d;

    // Combinational helpers
    logic              w_tick;
    logic              w_scan_tc;
    logic [C_W-1:0]    w_step_val;
    logic              w_step_wrap;
    logic [3:0]        w_digit;
    logic              w_blank_sel;

    // Active-low segment code {P,G,F,E,D,C,B,A}; P (decimal point) is off.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Free-running tick prescaler, independent of ce and load.
    always_comb begin
        w_tick     = (prescale_q == C_PRE_LAST);
        prescale_d = w_tick ? '0 : prescale_q + C_PW'(1);
    end

    // One-step count result; the carry/borrow out of the top digit is the wrap.
    generate
        if (BCD != 0) begin : g_bcd
            logic [3:0] w_dig;
            logic       w_carry;

            // Decimal ripple: up from >=9 gives 0 with carry, down from 0
            // gives 9 with borrow, down from an out-of-range digit just
            // decrements without borrowing.
            always_comb begin
                w_step_val = value_q;
                w_carry    = 1'b1;
                w_dig      = 4'd0;
                for (int k = 0; k < DIGITS; k++) begin
                    w_dig = value_q[4*k +: 4];
                    if (w_carry) begin
                        if (up) begin
                            if (w_dig >= 4'd9) begin
                                w_dig   = 4'd0;
                                w_carry = 1'b1;
                            end else begin
                                w_dig   = w_dig + 4'd1;
                                w_carry = 1'b0;
                            end
                        end else begin
                            if (w_dig == 4'd0) begin
                                w_dig   = 4'd9;
                                w_carry = 1'b1;
                            end else begin
                                w_dig   = w_dig - 4'd1;
                                w_carry = 1'b0;
                            end
                        end
                    end
                    w_step_val[4*k +: 4] = w_dig;
                end
                w_step_wrap = w_carry;
            end
        end else begin : g_hex
            // Plain binary +/-1 modulo 2^(4*DIGITS).
            always_comb begin
                w_step_val  = up ? value_q + C_W'(1) : value_q - C_W'(1);
                w_step_wrap = up ? (&value_q) : ~(|value_q);
            end
        end
    endgenerate

    // Counter next state: load beats a tick-qualified count, otherwise hold.
    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
        if (load) begin
            value_d = load_val;
        end else if (w_tick && ce) begin
            value_d = w_step_val;
            wrap_d  = w_step_wrap;
        end
    end

    // Scan divider and digit index rotation.
    always_comb begin
        w_scan_tc = (scan_q == C_SCAN_LAST);
        scan_d    = w_scan_tc ? '0 : scan_q + C_SW'(1);
        idx_d     = idx_q;
        if (w_scan_tc) begin
            idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + C_IW'(1);
        end
    end

`ifdef DISP_BLANK_EN
    logic [DIGITS-1:0] w_blank;
    logic              w_zero_run;

    // A digit is blanked when it and every digit above it are zero; digit 0 never.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run & (value_q[4*k +: 4] == 4'd0);
            w_blank[k] = w_zero_run;
        end
    end
`endif

    // Select the current digit and derive the registered anode/segment values.
    always_comb begin
        w_digit     = 4'd0;
        w_blank_sel = 1'b0;
        ano_d       = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == C_IW'(k)) begin
                w_digit  = value_q[4*k +: 4];
                ano_d[k] = 1'b0;
`ifdef DISP_BLANK_EN
                w_blank_sel = w_blank[k];
`endif
            end
        end
        cat_d = w_blank_sel ? 8'hFF : seg7(w_digit);
    end

    // All state registers; reset restarts both dividers and darkens the display.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescale_q <= '0;
            value_q    <= '0;
            wrap_q     <= 1'b0;
            scan_q     <= '0;
            idx_q      <= '0;
            ano_q      <= '1;
            cat_q      <= 8'hFF;
        end else begin
            prescale_q <= prescale_d;
            value_q    <= value_d;
            wrap_q     <= wrap_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            ano_q      <= ano_d;
            cat_q      <= cat_d;
        end
    end

    assign value = value_q;
    assign wrap  = wrap_q;
    assign ano   = ano_q;
    assign cat   = cat_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_counter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_counter_n
// Description : Scoreboard bench for disp_counter_n; a hex and a BCD instance
//               share one stimulus set (DIGITS=4, TICK_DIV=4, SCAN_DIV=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_counter_n;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        up;
    logic        load;
    logic [15:0] load_val;

    logic [15:0] hx_value, bc_value;
    logic        hx_wrap,  bc_wrap;
    logic [3:0]  hx_ano,   bc_ano;
    logic [7:0]  hx_cat,   bc_cat;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [15:0] hv;
        logic        hw;
        bit          cb;
        logic [15:0] bv;
        logic        bw;
        logic [3:0]  ano;
        logic [7:0]  cat;
    } exp_t;

    exp_t sb[$];

    logic [7:0] seg_tab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Tick-phase reference: prescaler restarts on reset and tick fires at 3.
    logic [1:0] m_pre;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) m_pre <= 2'd0;
        else          m_pre <= (m_pre == 2'd3) ? 2'd0 : m_pre + 2'd1;
    end

    disp_counter_n #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .BCD(0)) u_hex (
        .clk(clk), .reset_n(reset_n), .ce(ce), .up(up), .load(load), .load_val(load_val),
        .value(hx_value), .wrap(hx_wrap), .ano(hx_ano), .cat(hx_cat)
    );

    disp_counter_n #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .BCD(1)) u_bcd (
        .clk(clk), .reset_n(reset_n), .ce(ce), .up(up), .load(load), .load_val(load_val),
        .value(bc_value), .wrap(bc_wrap), .ano(bc_ano), .cat(bc_cat)
    );

    function automatic exp_t mk(input string n, input logic [15:0] hv, input logic hw,
                                input bit cb, input logic [15:0] bv, input logic bw,
                                input logic [3:0] a, input logic [7:0] c);
        exp_t e;
        e.name = n; e.hv = hv; e.hw = hw; e.cb = cb; e.bv = bv; e.bw = bw; e.ano = a; e.cat = c;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance so that the next edge taken is a tick edge, then take it.
    task automatic tick_step();
        for (int g = 0; g < 8 && m_pre != 2'd3; g++) step();
        step();
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        step();
        load     = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n = 1'b0; ce = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0;
        sb.push_back(mk("reset_hold", 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 4'hF, 8'hFF));
        repeat (3) step();
        e = sb.pop_front();
        n_checks++; if (hx_value !== e.hv) begin n_errors++; $display("FAIL %s value: got %h, expected %h", e.name, hx_value, e.hv); end
        n_checks++; if (hx_wrap  !== e.hw) begin n_errors++; $display("FAIL %s wrap: got %b, expected %b", e.name, hx_wrap, e.hw); end
        n_checks++; if (hx_ano   !== e.ano) begin n_errors++; $display("FAIL %s ano: got %b, expected %b", e.name, hx_ano, e.ano); end
        n_checks++; if (hx_cat   !== e.cat) begin n_errors++; $display("FAIL %s cat: got %h, expected %h", e.name, hx_cat, e.cat); end
        n_checks++; if (bc_value !== e.bv) begin n_errors++; $display("FAIL %s bcd value: got %h, expected %h", e.name, bc_value, e.bv); end
        n_checks++; if (bc_ano   !== e.ano) begin n_errors++; $display("FAIL %s bcd ano: got %b, expected %b", e.name, bc_ano, e.ano); end

        reset_n = 1'b1;
        sb.push_back(mk("reset_release", 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 4'b1110, 8'hC0));
        step();
        e = sb.pop_front();
        n_checks++; if (hx_value !== e.hv) begin n_errors++; $display("FAIL %s value: got %h, expected %h", e.name, hx_value, e.hv); end
        n_checks++; if (hx_ano   !== e.ano) begin n_errors++; $display("FAIL %s ano: got %b, expected %b", e.name, hx_ano, e.ano); end
        n_checks++; if (hx_cat   !== e.cat) begin n_errors++; $display("FAIL %s cat: got %h, expected %h", e.name, hx_cat, e.cat); end
        n_checks++; if (bc_cat   !== e.cat) begin n_errors++; $display("FAIL %s bcd cat: got %h, expected %h", e.name, bc_cat, e.cat); end
    endtask

    task automatic test_hex_count();
        exp_t e;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0: begin
                    ce = 1'b1; up = 1'b1;
                    sb.push_back(mk("hex_load", 16'hFFFE, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 8'h0));
                    do_load(16'hFFFE);
                end
                1: begin
                    sb.push_back(mk("hex_tick1", 16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 8'h0));
                    tick_step();
                end
                2: begin
                    sb.push_back(mk("hex_wrap", 16'h0000, 1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 8'h0));
                    tick_step();
                end
                3: begin
                    sb.push_back(mk("hex_wrap_end", 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 8'h0));
                    step();
                end
                default: begin
                    ce = 1'b0;
                    sb.push_back(mk("hex_hold", 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 8'h0));
                    tick_step();
                end
            endcase
            e = sb.pop_front();
            n_checks++; if (hx_value !== e.hv) begin n_errors++; $display("FAIL %s[%0d] value: got %h, expected %h", e.name, i, hx_value, e.hv); end
            n_checks++; if (hx_wrap  !== e.hw) begin n_errors++; $display("FAIL %s[%0d] wrap: got %b, expected %b", e.name, i, hx_wrap, e.hw); end
        end
    endtask

    task automatic test_bcd();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin ce = 1'b1; up = 1'b0;
                   sb.push_back(mk("bcd_load0", 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 4'h0, 8'h0)); do_load(16'h0000); end
                1: begin sb.push_back(mk("bcd_down_wrap", 16'hFFFF, 1'b1, 1'b1, 16'h9999, 1'b1, 4'h0, 8'h0)); tick_step(); end
                2: begin sb.push_back(mk("bcd_down", 16'hFFFE, 1'b0, 1'b1, 16'h9998, 1'b0, 4'h0, 8'h0)); tick_step(); end
                3: begin sb.push_back(mk("bcd_load_099A", 16'h099A, 1'b0, 1'b1, 16'h099A, 1'b0, 4'h0, 8'h0)); do_load(16'h099A); end
                4: begin up = 1'b1;
                   sb.push_back(mk("bcd_up_overrange", 16'h099B, 1'b0, 1'b1, 16'h1000, 1'b0, 4'h0, 8'h0)); tick_step(); end
                5: begin sb.push_back(mk("bcd_load_000B", 16'h000B, 1'b0, 1'b1, 16'h000B, 1'b0, 4'h0, 8'h0)); do_load(16'h000B); end
                6: begin up = 1'b0;
                   sb.push_back(mk("bcd_down_overrange", 16'h000A, 1'b0, 1'b1, 16'h000A, 1'b0, 4'h0, 8'h0)); tick_step(); end
                7: begin sb.push_back(mk("bcd_load_9999", 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b0, 4'h0, 8'h0)); do_load(16'h9999); end
                8: begin up = 1'b1;
                   sb.push_back(mk("bcd_up_wrap", 16'h999A, 1'b0, 1'b1, 16'h0000, 1'b1, 4'h0, 8'h0)); tick_step(); end
                default: begin
                   sb.push_back(mk("bcd_wrap_end", 16'h999A, 1'b0, 1'b1, 16'h0000, 1'b0, 4'h0, 8'h0)); step(); end
            endcase
            e = sb.pop_front();
            n_checks++; if (hx_value !== e.hv) begin n_errors++; $display("FAIL %s hex value: got %h, expected %h", e.name, hx_value, e.hv); end
            n_checks++; if (hx_wrap  !== e.hw) begin n_errors++; $display("FAIL %s hex wrap: got %b, expected %b", e.name, hx_wrap, e.hw); end
            n_checks++; if (bc_value !== e.bv) begin n_errors++; $display("FAIL %s bcd value: got %h, expected %h", e.name, bc_value, e.bv); end
            n_checks++; if (bc_wrap  !== e.bw) begin n_errors++; $display("FAIL %s bcd wrap: got %b, expected %b", e.name, bc_wrap, e.bw); end
        end
        ce = 1'b0;
    endtask

    task automatic test_priority();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin ce = 1'b0; up = 1'b1;
                   sb.push_back(mk("prio_preload", 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 4'h0, 8'h0)); do_load(16'hFFFF); end
                1: begin
                   for (int g = 0; g < 8 && m_pre != 2'd3; g++) step();
                   ce = 1'b1; up = 1'b1;
                   sb.push_back(mk("prio_load_on_tick", 16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0, 4'h0, 8'h0));
                   do_load(16'h1234);
                   ce = 1'b0;
                end
                default: begin
                   sb.push_back(mk("prio_after", 16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0, 4'h0, 8'h0)); step(); end
            endcase
            e = sb.pop_front();
            n_checks++; if (hx_value !== e.hv) begin n_errors++; $display("FAIL %s value: got %h, expected %h", e.name, hx_value, e.hv); end
            n_checks++; if (hx_wrap  !== e.hw) begin n_errors++; $display("FAIL %s wrap: got %b, expected %b", e.name, hx_wrap, e.hw); end
            n_checks++; if (bc_value !== e.bv) begin n_errors++; $display("FAIL %s bcd value: got %h, expected %h", e.name, bc_value, e.bv); end
            n_checks++; if (bc_wrap  !== e.bw) begin n_errors++; $display("FAIL %s bcd wrap: got %b, expected %b", e.name, bc_wrap, e.bw); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [15:0] vals [0:2];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                load = 1'b1; load_val = vals[i];
                sb.push_back(mk("b2b_load", vals[i], 1'b0, 1'b1, vals[i], 1'b0, 4'h0, 8'h0));
            end else begin
                load = 1'b0; load_val = 16'hDEAD;
                sb.push_back(mk("b2b_hold", vals[2], 1'b0, 1'b1, vals[2], 1'b0, 4'h0, 8'h0));
            end
            step();
            e = sb.pop_front();
            n_checks++; if (hx_value !== e.hv) begin n_errors++; $display("FAIL %s[%0d] value: got %h, expected %h", e.name, i, hx_value, e.hv); end
            n_checks++; if (bc_value !== e.bv) begin n_errors++; $display("FAIL %s[%0d] bcd value: got %h, expected %h", e.name, i, bc_value, e.bv); end
        end
    endtask

    task automatic test_scan(input logic [15:0] v, input string tag);
        exp_t       e;
        logic [3:0] prev;
        logic [3:0] dig;
        logic [7:0] ec;
        logic       blank;
        bit         found;
        int         d;
        ce = 1'b0;
        do_load(v);
        step();
        found = 1'b0;
        prev  = hx_ano;
        for (int g = 0; g < 20 && !found; g++) begin
            step();
            if (prev == 4'b0111 && hx_ano == 4'b1110) found = 1'b1;
            else prev = hx_ano;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL %s_sync: anode never stepped 0111->1110, last ano=%b", tag, hx_ano);
        end else begin
            for (int j = 0; j < 8; j++) begin
                d   = j / 2;
                dig = v[4*d +: 4];
`ifdef DISP_BLANK_EN
                blank = (d > 0) && ((v >> (4*d)) == 16'h0);
`else
                blank = 1'b0;
`endif
                ec = blank ? 8'hFF : seg_tab[dig];
                sb.push_back(mk(tag, v, 1'b0, 1'b0, v, 1'b0, ~(4'b0001 << d), ec));
                if (j > 0) step();
                e = sb.pop_front();
                n_checks++; if (hx_ano !== e.ano) begin n_errors++; $display("FAIL %s[%0d] ano: got %b, expected %b", e.name, j, hx_ano, e.ano); end
                n_checks++; if (hx_cat !== e.cat) begin n_errors++; $display("FAIL %s[%0d] cat: got %h, expected %h", e.name, j, hx_cat, e.cat); end
                n_checks++; if (hx_value !== e.hv) begin n_errors++; $display("FAIL %s[%0d] value: got %h, expected %h", e.name, j, hx_value, e.hv); end
            end
        end
    endtask

    // Reset in the middle of activity must restart the tick prescaler from 0.
    task automatic test_reset_mid();
        exp_t e;
        ce = 1'b0;
        do_load(16'hABCD);
        step();
        ce = 1'b1; up = 1'b1;
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin sb.push_back(mk("mid_reset", 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 4'hF, 8'hFF)); step(); end
                1: begin reset_n = 1'b1;
                   sb.push_back(mk("mid_release", 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 4'b1110, 8'hC0)); step(); end
                2: begin sb.push_back(mk("mid_pre2", 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 4'b1110, 8'hC0)); step(); end
                3: begin sb.push_back(mk("mid_pre3", 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 4'b1101, 8'hC0)); step(); end
                default: begin
                   sb.push_back(mk("mid_first_tick", 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b0, 4'b1101, 8'hC0)); step(); end
            endcase
            e = sb.pop_front();
            n_checks++; if (hx_value !== e.hv) begin n_errors++; $display("FAIL %s value: got %h, expected %h", e.name, hx_value, e.hv); end
            n_checks++; if (hx_wrap  !== e.hw) begin n_errors++; $display("FAIL %s wrap: got %b, expected %b", e.name, hx_wrap, e.hw); end
            n_checks++; if (hx_ano   !== e.ano) begin n_errors++; $display("FAIL %s ano: got %b, expected %b", e.name, hx_ano, e.ano); end
            n_checks++; if (hx_cat   !== e.cat) begin n_errors++; $display("FAIL %s cat: got %h, expected %h", e.name, hx_cat, e.cat); end
            n_checks++; if (bc_value !== e.bv) begin n_errors++; $display("FAIL %s bcd value: got %h, expected %h", e.name, bc_value, e.bv); end
        end
        ce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hex_count();
        test_bcd();
        test_priority();
        test_back_to_back();
        test_scan(16'hA5C3, "scan_A5C3");
        test_scan(16'h0070, "scan_0070");
        test_scan(16'h0000, "scan_0000");
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
